ni_tx_packetizer: RTL
=====================

Name: ni_tx_packetizer

Overview:
- Network-interface transmit side for the 4x4 mesh. Accepts a send request (destination plus payload words) from the local core and emits a wormhole packet into the router's local input port.
- Packet format: one head flit, then 1..4 payload flits; the last flit is tagged tail.
- The head flit carries the 4-bit {y,x} destination that the router's XY route stage decodes into an output port.

Parameters:
- SRC_ADDR, 4'b0000, this node's address: [3:2] = y, [1:0] = x.
- DATA_W, 16, payload width in bits; must be >= 10.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  core offers a send request.
- req_ready  output  1  block can accept a request.
- req_dest  input  4  destination address {y[1:0], x[1:0]}.
- req_len  input  2  payload flit count minus 1 (0..3 encodes 1..4 flits).
- pld_valid  input  1  payload word available.
- pld_ready  output  1  block takes the payload word this cycle.
- pld_data  input  DATA_W  payload word.
- flit_valid  output  1  flit presented to the router local port.
- flit_ready  input  1  router accepts the flit.
- flit_type  output  2  flit type: 01 head, 10 body, 11 tail, 00 idle.
- flit_data  output  DATA_W  flit payload.
- err_self  output  1  one-cycle pulse: a request was rejected because dest == SRC_ADDR.
- pkt_sent  output  8  count of packets completed; tail accepted by the router; wraps at 255 -> 0.

Behaviour:
- Reset (asynchronous, any time):
  - State -> IDLE.
  - flit_valid=0, flit_type=00, flit_data=0.
  - req_ready=0 while rst is high, then 1 in IDLE.
  - pld_ready=0, err_self=0, pkt_sent=0.
  - A packet in flight is truncated with no tail emitted; the router is reset on the same rst.
- States: IDLE, HEAD, BODY, DRAIN.
- IDLE:
  - req_ready=1.
  - On req_valid, latch dest, len and remaining = len+1.
  - If req_dest == SRC_ADDR: stay in IDLE, pulse err_self the next cycle, emit no flits.
  - Otherwise go to HEAD. The head flit is registered: flit_valid=1 in the cycle after acceptance.
- HEAD:
  - flit_type=01.
  - flit_data[3:0] = dest, [7:4] = SRC_ADDR, [9:8] = len, upper bits 0.
  - Hold all outputs stable until flit_ready=1, then go to BODY.
- BODY:
  - pld_ready = (!flit_valid || flit_ready) && remaining != 0.
  - On a pld handshake, load the output register with pld_data.
  - Type is 11 if remaining == 1, else 10. Decrement remaining.
  - If the loaded flit is the tail, go to DRAIN.
  - If pld_valid is low while the output drains, flit_valid drops to 0 (bubble); this is legal and the type is held at 00.
  - Back-to-back transfers: one flit per cycle when pld_valid and flit_ready stay high.
- DRAIN:
  - Hold the tail flit until flit_ready=1.
  - On that handshake: pkt_sent += 1 and go to IDLE.
  - req_ready rises in the cycle after the tail handshake, so there is one idle bubble between packets.
- Flit handshake rules:
  - Once flit_valid=1, flit_type and flit_data are stable until flit_ready=1.
  - flit_valid never deasserts without a handshake.
- Minimum packet (len=0): head, then one tail flit.
- Simultaneous events:
  - req_valid is ignored outside IDLE (req_ready=0).
  - pld_valid is ignored outside BODY.
  - The tail handshake and a new req_valid in the same cycle: the request waits one cycle.
- Widths: remaining is 3 bits (max 4). Addresses are compared over all 4 bits.

Decomposition:
- Shared package mesh_pkg:
  - Flit type constants FLIT_IDLE/HEAD/BODY/TAIL (00/01/10/11).
  - Head-field bit offsets DEST_LSB=0, SRC_LSB=4, LEN_LSB=8.
  - Port one-hot constants, shared with the route stage: LOCAL 0000, SOUTH 0001, WEST 0010, EAST 0100, NORTH 1000.
- Sub-module flit_out_reg: a single-entry output register with the valid/ready hold rule. ni_tx_packetizer instantiates it; the FSM and counters stay in the top level.

Test Plan:
- SRC_ADDR=0000, req dest=0110, len=2, payload A1,B2,C3, flit_ready=1 -> flits in consecutive cycles:
  - head with data 0x0206, type 01;
  - A1 type 10, B2 type 10, C3 type 11;
  - pkt_sent=1 and req_ready back high one cycle later.
- Same packet with flit_ready low for 3 cycles on the head and 2 on the body -> flit outputs unchanged throughout each stall; no payload is lost or duplicated.
- req dest=0000 equal to SRC_ADDR -> err_self pulses one cycle; flit_valid stays 0; pkt_sent unchanged.
- len=0, one payload 0x5A5A with a pld_valid gap of 2 cycles -> head, then bubble cycles with flit_valid=0, then tail 0x5A5A type 11.
- rst asserted while BODY is mid-packet -> the same cycle (asynchronous): flit_valid=0, state IDLE, pkt_sent=0; after release, req_ready=1.
- 256 minimum packets sent -> pkt_sent wraps to 0 after the 256th tail.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared mesh definitions: flit type codes, head-flit field offsets,
// router port one-hot codes and the NI transmit FSM state type.
package mesh_pkg;

  localparam logic [1:0] FLIT_IDLE = 2'b00;
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  localparam int DEST_LSB = 0;
  localparam int SRC_LSB  = 4;
  localparam int LEN_LSB  = 8;

  localparam logic [3:0] LOCAL = 4'b0000;
  localparam logic [3:0] SOUTH = 4'b0001;
  localparam logic [3:0] WEST  = 4'b0010;
  localparam logic [3:0] EAST  = 4'b0100;
  localparam logic [3:0] NORTH = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY,
    ST_DRAIN
  } tx_state_e;

endpackage

// File: rtl/flit_out_reg.sv
// Single-entry flit output register: holds type/data stable until ready.
// Ports: load_i/type_i/data_i load side, valid_o/ready_i/type_o/data_o out.
module flit_out_reg
  import mesh_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [1:0]        type_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [1:0]        type_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [1:0]        type_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      type_q  <= FLIT_IDLE;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      type_q  <= type_i;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      // drained with nothing behind it: bubble reads as idle
      valid_q <= 1'b0;
      type_q  <= FLIT_IDLE;
      data_q  <= '0;
    end
  end

  assign valid_o = valid_q;
  assign type_o  = type_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ni_tx_packetizer.sv
// NI transmit side: turns a core send request into a head+payload packet.
// Ports: req_* request, pld_* payload, flit_* router link, err_self, pkt_sent.
module ni_tx_packetizer
  import mesh_pkg::*;
#(
  parameter logic [3:0] SRC_ADDR = 4'b0000,
  parameter int         DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_dest,
  input  logic [1:0]        req_len,
  input  logic              pld_valid,
  output logic              pld_ready,
  input  logic [DATA_W-1:0] pld_data,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic [1:0]        flit_type,
  output logic [DATA_W-1:0] flit_data,
  output logic              err_self,
  output logic [7:0]        pkt_sent
);

  tx_state_e         state_q, state_d;
  logic [2:0]        rem_q, rem_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ld;
  logic [1:0]        ld_type;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] head_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= 3'd0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    head_w = '0;
    head_w[DEST_LSB +: 4] = req_dest;
    head_w[SRC_LSB +: 4]  = SRC_ADDR;
    head_w[LEN_LSB +: 2]  = req_len;
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    ld        = 1'b0;
    ld_type   = FLIT_IDLE;
    ld_data   = '0;
    req_ready = 1'b0;
    pld_ready = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          rem_d = {1'b0, req_len} + 3'd1;
          if (req_dest == SRC_ADDR) begin
            err_d = 1'b1;
          end else begin
            ld      = 1'b1;
            ld_type = FLIT_HEAD;
            ld_data = head_w;
            state_d = ST_HEAD;
          end
        end
      end
      ST_HEAD: begin
        if (flit_ready) state_d = ST_BODY;
      end
      ST_BODY: ;
      ST_DRAIN: begin
        if (flit_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // the head's handshake cycle already frees the register, so the
    // first payload word can follow the head with no gap
    if ((state_q == ST_BODY || (state_q == ST_HEAD && flit_ready))
        && (!flit_valid || flit_ready) && rem_q != 3'd0)
      pld_ready = 1'b1;

    if (pld_ready && pld_valid) begin
      ld      = 1'b1;
      ld_data = pld_data;
      ld_type = (rem_q == 3'd1) ? FLIT_TAIL : FLIT_BODY;
      rem_d   = rem_q - 3'd1;
      if (rem_q == 3'd1) state_d = ST_DRAIN;
    end
  end

  flit_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ld),
    .type_i  (ld_type),
    .data_i  (ld_data),
    .ready_i (flit_ready),
    .valid_o (flit_valid),
    .type_o  (flit_type),
    .data_o  (flit_data)
  );

  assign err_self = err_q;
  assign pkt_sent = cnt_q;

endmodule
